// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue handshake bundle: instruction-memory request port, redirect input
// and the decoder-facing FIFO head port.
interface inst_fetch_queue_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output mem_req, mem_addr, inst_valid, inst_out, inst_pc,
        input  mem_ready, mem_inst, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst_out, inst_pc,
        output mem_ready, mem_inst, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: one-outstanding word fetches into a DEPTH-entry {pc, inst}
// FIFO drained by decode; redirect flushes the FIFO and squashes the in-flight fetch.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_fetch_queue_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_inst_q [DEPTH];
    logic          push;
    logic          pop;
    logic [CW:0]   count_nx;

    assign bus.mem_req    = (state_q != IDLE);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst_out   = fifo_inst_q[rd_ptr_q];
    assign bus.inst_pc    = fifo_pc_q[rd_ptr_q];

    always_comb begin
        pop        = bus.inst_valid & bus.inst_ready & ~bus.redirect;
        push       = (state_q == REQ) & bus.mem_ready & ~bus.redirect;
        count_nx   = {1'b0, count_q} + (CW+1)'(push) - (CW+1)'(pop);
        state_d    = state_q;
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;

        case (state_q)
            IDLE: begin
                if (!bus.redirect && count_nx < DEPTH_C) begin
                    state_d    = REQ;
                    mem_addr_d = pc_q;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    // a response still owed must be swallowed before refetching
                    state_d = bus.mem_ready ? IDLE : DISCARD;
                end else if (bus.mem_ready) begin
                    pc_d = pc_q + 32'd4;
                    if (count_nx < DEPTH_C) begin
                        mem_addr_d = pc_q + 32'd4;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (bus.mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.redirect) begin
            pc_d     = bus.redirect_pc;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d  = count_nx[CW-1:0];
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            mem_addr_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= pc_q;
            fifo_inst_q[wr_ptr_q] <= bus.mem_inst;
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: memory responder, directed scenarios, random traffic and
// a scoreboard that follows the fetch stream from the observed port protocol.
module tb_inst_fetch_queue;
    localparam int unsigned DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] IMASK    = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    inst_fetch_queue_if bus ();

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Memory responder: answers each request after a chosen latency, and throws stray
    // mem_ready pulses while no request is open.
    int mem_lat  = 2;
    bit stray_en = 1'b1;
    bit waiting  = 1'b0;
    int wcnt     = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ready = 1'b0;
            if (!rst_n) begin
                waiting = 1'b0;
            end else if (bus.mem_req) begin
                if (!waiting) begin
                    waiting = 1'b1;
                    wcnt    = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
                end
                if (wcnt == 0) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_inst  = bus.mem_addr ^ IMASK;
                    waiting       = 1'b0;
                end else begin
                    wcnt--;
                end
            end else begin
                waiting = 1'b0;
                if (stray_en && $urandom_range(0, 7) == 0) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_inst  = $urandom;
                end
            end
        end
    end

    // Reference model: the fetch stream is RESET_PC, +4, +4 ... restarted at each redirect.
    // A response is accepted only if no redirect touched its request.
    ent_t        q[$];
    logic [31:0] next_fetch = RESET_PC;
    bit          stale      = 1'b0;
    bit          prev_open  = 1'b0;
    logic [31:0] prev_addr  = '0;
    int          push_cnt   = 0;

    always @(negedge clk) begin
        ent_t e;
        bit   pop_ev;
        if (!rst_n) begin
            q.delete();
            next_fetch = RESET_PC;
            stale      = 1'b0;
            prev_open  = 1'b0;
            push_cnt   = 0;
        end else begin
            chk("inst_valid", bus.inst_valid, (q.size() != 0));
            if (prev_open) begin
                chk("req_held", bus.mem_req, 1'b1);
                chk("addr_stable", bus.mem_addr, prev_addr);
            end
            pop_ev = bus.inst_valid && bus.inst_ready && !bus.redirect;
            if (pop_ev && q.size() != 0) begin
                e = q.pop_front();
                chk("pop_pc", bus.inst_pc, e.pc);
                chk("pop_inst", bus.inst_out, e.inst);
            end
            if (bus.mem_req) begin
                if (bus.mem_ready && !bus.redirect && !stale) begin
                    chk("fetch_addr", bus.mem_addr, next_fetch);
                    chk("no_overflow", (q.size() < DEPTH), 1'b1);
                    e.pc   = next_fetch;
                    e.inst = bus.mem_inst;
                    q.push_back(e);
                    push_cnt++;
                    next_fetch = next_fetch + 32'd4;
                end
                if (bus.mem_ready) stale = 1'b0;
                else if (bus.redirect) stale = 1'b1;
            end
            prev_open = bus.mem_req && !bus.mem_ready;
            prev_addr = bus.mem_addr;
            if (bus.redirect) begin
                q.delete();
                next_fetch = bus.redirect_pc;
            end
        end
    end

    initial begin
        int          rdy_pct;
        logic [31:0] rp;
        rst_n           = 1'b0;
        bus.mem_ready   = 1'b0;
        bus.mem_inst    = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready  = 1'b1;
        rdy_pct         = 50;

        // 1: reset values, first request one cycle after release, steady stream
        repeat (3) step();
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_inst_valid", bus.inst_valid, 1'b0);
        rst_n = 1'b1;
        chk("pre_first_req", bus.mem_req, 1'b0);
        step();
        chk("first_req", bus.mem_req, 1'b1);
        chk("first_addr", bus.mem_addr, RESET_PC);
        repeat (40) step();

        // 2: decoder stalled, zero-latency memory fills exactly DEPTH entries
        rst_n = 1'b0;
        step();
        rst_n          = 1'b1;
        bus.inst_ready = 1'b0;
        mem_lat        = 0;
        repeat (30) step();
        chk("full_mem_req", bus.mem_req, 1'b0);
        chk("full_pushes", push_cnt, DEPTH);
        chk("full_valid", bus.inst_valid, 1'b1);
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 10 && !bus.mem_req; i++) step();
        chk("resume_req", bus.mem_req, 1'b1);
        chk("resume_addr", bus.mem_addr, 32'd32);
        repeat (20) step();

        // 3: redirect while a 3-cycle response is pending
        mem_lat = 3;
        for (int i = 0; i < 20 && !(bus.mem_req && !bus.mem_ready && waiting); i++) step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        step();
        bus.redirect = 1'b0;
        chk("t3_flushed", bus.inst_valid, 1'b0);
        for (int i = 0; i < 30 && !bus.inst_valid; i++) step();
        chk("t3_valid", bus.inst_valid, 1'b1);
        chk("t3_head_pc", bus.inst_pc, 32'h100);
        repeat (10) step();

        // 4: redirect coinciding with mem_ready and a pop
        mem_lat        = 1;
        bus.inst_ready = 1'b0;
        repeat (6) step();
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 20 && !(bus.mem_ready && bus.inst_valid); i++) step();
        chk("t4_setup", bus.mem_ready && bus.inst_valid, 1'b1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        step();
        bus.redirect = 1'b0;
        chk("t4_flushed", bus.inst_valid, 1'b0);
        for (int i = 0; i < 10 && !bus.mem_req; i++) step();
        chk("t4_req", bus.mem_req, 1'b1);
        chk("t4_addr", bus.mem_addr, 32'h200);
        repeat (10) step();

        // 5: two redirects while the squashed response is still owed
        mem_lat = 6;
        for (int i = 0; i < 30 && !(bus.mem_req && waiting && wcnt >= 3); i++) step();
        chk("t5_setup", bus.mem_req && waiting && wcnt >= 3, 1'b1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h300;
        step();
        bus.redirect_pc = 32'h400;
        step();
        bus.redirect = 1'b0;
        mem_lat      = 1;
        for (int i = 0; i < 40 && !bus.inst_valid; i++) step();
        chk("t5_valid", bus.inst_valid, 1'b1);
        chk("t5_head_pc", bus.inst_pc, 32'h400);

        // 6: asynchronous reset mid-request with three entries queued
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h500;
        step();
        bus.redirect = 1'b0;
        for (int i = 0; i < 30 && !(q.size() == 3 && bus.mem_req && !bus.mem_ready); i++) step();
        chk("t6_setup", (q.size() == 3) && bus.mem_req, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_mem_req", bus.mem_req, 1'b0);
        chk("t6_inst_valid", bus.inst_valid, 1'b0);
        chk("t6_mem_addr", bus.mem_addr, 32'h0);
        step();
        step();
        rst_n          = 1'b1;
        bus.inst_ready = 1'b1;
        chk("t6_idle", bus.mem_req, 1'b0);
        step();
        chk("t6_restart_req", bus.mem_req, 1'b1);
        chk("t6_restart_addr", bus.mem_addr, RESET_PC);
        repeat (20) step();

        // random traffic: latency, decoder stalls, redirects (incl. near address wrap)
        mem_lat = -1;
        for (int i = 0; i < 2000; i++) begin
            if (i % 64 == 0) rdy_pct = $urandom_range(0, 100);
            bus.inst_ready = ($urandom_range(0, 99) < rdy_pct);
            bus.redirect   = ($urandom_range(0, 24) == 0);
            rp             = $urandom;
            rp[1:0]        = 2'b00;
            if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0;
            bus.redirect_pc = rp;
            step();
        end
        bus.redirect   = 1'b0;
        bus.inst_ready = 1'b1;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
